pwm_decoder_wb: RTL and testbench
=================================

Name: pwm_decoder_wb

Overview:
- Wishbone B4 classic, read-only slave that measures the high-time of six RC-style PWM inputs (servo/ESC/receiver signals) in microseconds.
- Sits on the flight-controller FPGA Wishbone bus so the host can read receiver channel widths.
- Each channel is independently synchronized, edge-detected and timed against a 1 µs tick derived from the system clock.

Parameters:
- clockFreq, 100000000, system clock frequency in Hz; must be an integer multiple of 1000000 and ≥ 1000000. The 1 µs tick divisor is clockFreq/1000000.
- TIMEOUT_US, 25000, µs without a completed pulse, or µs of continuous high, after which a channel is declared invalid.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- wb_adr_i  in  32  byte address; only bits [4:2] are decoded.
- wb_dat_i  in  32  write data; ignored.
- wb_dat_o  out  32  read data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte selects; ignored (always full-word access).
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error; tied 0.
- wb_rty_o  out  1  retry; tied 0.
- wb_cyc_i  in  1  cycle valid.
- i_pwm_0 .. i_pwm_5  in  1 each  asynchronous PWM inputs.

Behaviour:
Reset (i_rstn=0, asynchronous):
- wb_ack_o=0, wb_dat_o=0.
- All width registers = 0, all valid and new flags = 0.
- All counters, synchronizers and the prescaler = 0.

Tick:
- Prescaler counts 0..clockFreq/1e6-1 and emits a one-cycle tick on wrap.
- With clockFreq=1000000 the tick is asserted every cycle.

Per channel:
- Input passes a 2-flop synchronizer; edge detection uses the 2nd and 3rd flops, so edges are seen 2-3 cycles after the pin changes.
- Rising edge clears the high counter to 0.
- Each tick while the line is high increments the high counter, saturating at 0xFFFF.
- Falling edge latches the counter into width[15:0], sets valid=1 and sets new=1.
- Idle counter is cleared on every falling edge and incremented each tick otherwise.
- Idle counter ≥ TIMEOUT_US, or high counter ≥ TIMEOUT_US: valid=0 and width=0. The timeout re-arms on the next falling edge.
- If a rising and falling edge are seen in the same cycle (glitch shorter than sync resolution), no capture occurs.

Register map (word index = wb_adr_i[4:2]):
- 0..5, CHn: [15:0] width in µs; [30:16]=0; [31]=valid. Reading CHn clears new[n].
- 6, STATUS: [5:0] valid[5:0]; [13:8] new[5:0]; other bits 0.
- 7: reads 0.
- If a capture and a read-clear of new[n] occur in the same cycle, the capture wins and new stays 1.

Wishbone:
- When wb_cyc_i & wb_stb_i & !wb_ack_o, drive wb_ack_o=1 on the next cycle for exactly one cycle; wb_dat_o is registered with the same timing.
- Back-to-back requests each get ack on alternate cycles.
- Writes are acked and have no effect.
- Addresses beyond 0x1C alias via bits [4:2].
- Dropping wb_cyc_i mid-cycle: the pending ack still pulses once and the master ignores it.
- wb_dat_o holds its last value when not acking.
- Reset asserted mid-transaction clears ack immediately.

Test Plan:
1. Reset, then clockFreq=1000000: read CH0..5 and STATUS → all 0x00000000; wb_err_o=wb_rty_o=0 throughout.
2. Drive i_pwm_1 high for 1500 cycles, then low → CH1 reads 0x800005DC (±1). STATUS bit1 and bit9 set before the read; bit9 clear after reading CH1.
3. i_pwm_1 repeating 500 high / 2000 low for several periods → CH1 stable at 500 (±1) and valid; all other channels remain 0 and invalid.
4. Stop toggling i_pwm_1 (held low) for 25000 cycles → CH1 reads 0x00000000 and STATUS bit1=0. Resuming pulses restores valid on the first falling edge.
5. clockFreq=100000000, i_pwm_0 high 200000 cycles → CH0 = 0x800007D0 (2000 µs). Concurrently i_pwm_5 high 100000 cycles → CH5 = 0x800003E8, with both channels independent.
6. Write 0xFFEEDDCC to CH2 with wb_we_i=1 → ack one cycle after stb, CH2 unchanged. Hold stb/cyc for 4 cycles → ack pulses on alternate cycles, never two consecutive.

Source files
------------

// File: rtl/pwm_decoder_wb_if.sv
// Wishbone B4 classic signal bundle for the PWM decoder register port.
interface pwm_decoder_wb_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic        wb_cyc_i;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/pwm_decoder_wb.sv
// Read-only Wishbone slave measuring the high time of six RC PWM inputs in
// microseconds. Each channel is synchronized, edge-detected and timed
// against a 1 us tick; stale or stuck channels are reported invalid.
module pwm_decoder_wb #(
  parameter int clockFreq  = 100000000,
  parameter int TIMEOUT_US = 25000
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  pwm_decoder_wb_if.slave         wb,
  input  logic                    i_pwm_0,
  input  logic                    i_pwm_1,
  input  logic                    i_pwm_2,
  input  logic                    i_pwm_3,
  input  logic                    i_pwm_4,
  input  logic                    i_pwm_5
);

  localparam int          DIV    = clockFreq / 1000000;
  localparam logic [31:0] DIV_M1 = 32'(DIV - 1);
  // Idle counter only needs to reach the timeout, then it parks there.
  localparam int          IW     = $clog2(TIMEOUT_US + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_US);
  localparam logic [31:0] TO_W   = 32'(TIMEOUT_US);

  logic [31:0]   presc_r;
  logic          tick_s;
  logic [5:0]    pwm_s;
  logic [5:0]    sync1_r, sync2_r, sync3_r;
  logic [5:0]    rise_s, fall_s, cap_s, timeout_s, clr_s;
  logic [15:0]   high_cnt_r [6];
  logic [IW-1:0] idle_cnt_r [6];
  logic [15:0]   width_r    [6];
  logic [5:0]    valid_r, new_r;
  logic          req_s, rd_s, ack_r;
  logic [2:0]    word_s;
  logic [31:0]   rdata_s, dat_r;
  logic          unused_s;

  assign pwm_s  = {i_pwm_5, i_pwm_4, i_pwm_3, i_pwm_2, i_pwm_1, i_pwm_0};
  assign tick_s = (presc_r >= DIV_M1);

  // Data, byte selects and upper/lower address bits play no part in decoding.
  assign unused_s = ^{wb.wb_dat_i, wb.wb_sel_i, wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

  // Free-running prescaler producing the 1 us tick on wrap.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      presc_r <= 32'd0;
    end else if (presc_r >= DIV_M1) begin
      presc_r <= 32'd0;
    end else begin
      presc_r <= presc_r + 32'd1;
    end
  end

  // Edge detection on the 2nd/3rd flops; a same-cycle rise and fall never captures.
  always_comb begin
    rise_s = sync2_r & ~sync3_r;
    fall_s = ~sync2_r & sync3_r;
    cap_s  = fall_s & ~rise_s;
    for (int n = 0; n < 6; n++) begin
      timeout_s[n] = (32'(high_cnt_r[n]) >= TO_W) || (32'(idle_cnt_r[n]) >= TO_W);
    end
  end

  assign req_s  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_r;
  assign rd_s   = req_s & ~wb.wb_we_i;
  assign word_s = wb.wb_adr_i[4:2];

  // Accepted reads of a channel register clear that channel's new flag.
  always_comb begin
    clr_s = 6'd0;
    if (rd_s && (word_s < 3'd6)) begin
      clr_s[word_s] = 1'b1;
    end else begin
      clr_s = 6'd0;
    end
  end

  // Per-channel synchronizers, high/idle counters, captured width and flags.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_r <= 6'd0;
      sync2_r <= 6'd0;
      sync3_r <= 6'd0;
      valid_r <= 6'd0;
      new_r   <= 6'd0;
      for (int n = 0; n < 6; n++) begin
        high_cnt_r[n] <= 16'd0;
        idle_cnt_r[n] <= '0;
        width_r[n]    <= 16'd0;
      end
    end else begin
      sync1_r <= pwm_s;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      for (int n = 0; n < 6; n++) begin
        if (rise_s[n]) begin
          high_cnt_r[n] <= 16'd0;
        end else if (tick_s && sync2_r[n] && (high_cnt_r[n] != 16'hFFFF)) begin
          high_cnt_r[n] <= high_cnt_r[n] + 16'd1;
        end

        if (fall_s[n]) begin
          idle_cnt_r[n] <= '0;
        end else if (tick_s && (idle_cnt_r[n] != IDLE_MAX)) begin
          idle_cnt_r[n] <= idle_cnt_r[n] + 1'b1;
        end

        if (cap_s[n]) begin
          width_r[n] <= high_cnt_r[n];
          valid_r[n] <= 1'b1;
        end else if (timeout_s[n]) begin
          width_r[n] <= 16'd0;
          valid_r[n] <= 1'b0;
        end

        // A capture in the same cycle as a read-clear keeps the flag set.
        if (cap_s[n]) begin
          new_r[n] <= 1'b1;
        end else if (clr_s[n]) begin
          new_r[n] <= 1'b0;
        end
      end
    end
  end

  // Register read multiplexer.
  always_comb begin
    rdata_s = 32'd0;
    case (word_s)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5:
        rdata_s = {valid_r[word_s], 15'd0, width_r[word_s]};
      3'd6:
        rdata_s = {18'd0, new_r, 2'd0, valid_r};
      default:
        rdata_s = 32'd0;
    endcase
  end

  // Single-cycle ack with registered read data; data holds between acks.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= req_s;
      if (req_s) begin
        dat_r <= rdata_s;
      end
    end
  end

  assign wb.wb_ack_o = ack_r;
  assign wb.wb_dat_o = dat_r;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;

endmodule

// File: tb/tb_pwm_decoder_wb.sv
// Directed self-checking bench for pwm_decoder_wb: a 1 MHz instance for the
// timing/timeout/bus checks and a 10 MHz instance for the prescaled tick.
module tb_pwm_decoder_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  pa = 6'd0;
  logic [5:0]  pb = 6'd0;
  int          total = 0;
  int          bad = 0;
  logic        err_seen = 1'b0;
  logic [31:0] d;

  pwm_decoder_wb_if bus_a ();
  pwm_decoder_wb_if bus_b ();

  pwm_decoder_wb #(.clockFreq(1000000), .TIMEOUT_US(25000)) dut_a (
    .i_clk(clk), .i_rstn(rst_n), .wb(bus_a),
    .i_pwm_0(pa[0]), .i_pwm_1(pa[1]), .i_pwm_2(pa[2]),
    .i_pwm_3(pa[3]), .i_pwm_4(pa[4]), .i_pwm_5(pa[5])
  );

  pwm_decoder_wb #(.clockFreq(10000000), .TIMEOUT_US(25000)) dut_b (
    .i_clk(clk), .i_rstn(rst_n), .wb(bus_b),
    .i_pwm_0(pb[0]), .i_pwm_1(pb[1]), .i_pwm_2(pb[2]),
    .i_pwm_3(pb[3]), .i_pwm_4(pb[4]), .i_pwm_5(pb[5])
  );

  always #5 clk = ~clk;

  // Sticky flag for any error/retry assertion on either bus.
  always @(negedge clk) begin
    if (bus_a.wb_err_o || bus_a.wb_rty_o || bus_b.wb_err_o || bus_b.wb_rty_o)
      err_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Width readings may be off by one tick; fold an in-tolerance value onto exp.
  function automatic logic [31:0] near1(input logic [31:0] got, input logic [31:0] exp);
    if ((got[31:16] == exp[31:16]) &&
        ((got[15:0] == exp[15:0]) || (got[15:0] == exp[15:0] + 16'd1) ||
         (got[15:0] + 16'd1 == exp[15:0])))
      return exp;
    else
      return got;
  endfunction

  task automatic rd(input int b, input logic [31:0] addr, output logic [31:0] dv);
    int   n;
    logic ack;
    @(negedge clk);
    if (b == 0) begin
      bus_a.wb_adr_i = addr; bus_a.wb_we_i = 1'b0; bus_a.wb_cyc_i = 1'b1; bus_a.wb_stb_i = 1'b1;
    end else begin
      bus_b.wb_adr_i = addr; bus_b.wb_we_i = 1'b0; bus_b.wb_cyc_i = 1'b1; bus_b.wb_stb_i = 1'b1;
    end
    n = 0;
    ack = 1'b0;
    while (!ack && n < 8) begin
      @(negedge clk);
      n++;
      ack = (b == 0) ? bus_a.wb_ack_o : bus_b.wb_ack_o;
    end
    dv = (b == 0) ? bus_a.wb_dat_o : bus_b.wb_dat_o;
    chk("rd_ack", {31'd0, ack}, 32'd1);
    bus_a.wb_cyc_i = 1'b0; bus_a.wb_stb_i = 1'b0;
    bus_b.wb_cyc_i = 1'b0; bus_b.wb_stb_i = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus_a.wb_adr_i = 32'd0; bus_a.wb_dat_i = 32'd0; bus_a.wb_we_i = 1'b0;
    bus_a.wb_sel_i = 4'hF;  bus_a.wb_stb_i = 1'b0;  bus_a.wb_cyc_i = 1'b0;
    bus_b.wb_adr_i = 32'd0; bus_b.wb_dat_i = 32'd0; bus_b.wb_we_i = 1'b0;
    bus_b.wb_sel_i = 4'hF;  bus_b.wb_stb_i = 1'b0;  bus_b.wb_cyc_i = 1'b0;

    // Reset state
    wait_cyc(3);
    chk("rst_ack", {31'd0, bus_a.wb_ack_o}, 32'd0);
    chk("rst_dat", bus_a.wb_dat_o, 32'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // 1: all registers zero after reset, including the reserved word
    for (int i = 0; i < 8; i++) begin
      rd(0, 32'(i * 4), d);
      chk($sformatf("init_w%0d", i), d, 32'd0);
    end

    // 2: single 1500 us pulse on channel 1
    pa[1] = 1'b1; wait_cyc(1500);
    pa[1] = 1'b0; wait_cyc(6);
    rd(0, 32'h18, d); chk("t2_stat_pre", d, 32'h0000_0202);
    rd(0, 32'h04, d); chk("t2_ch1", near1(d, 32'h8000_05DC), 32'h8000_05DC);
    rd(0, 32'h18, d); chk("t2_stat_post", d, 32'h0000_0002);

    // 3: repeating 500 high / 2000 low
    for (int k = 0; k < 4; k++) begin
      pa[1] = 1'b1; wait_cyc(500);
      pa[1] = 1'b0; wait_cyc(2000);
      if (k >= 2) begin
        rd(0, 32'h04, d); chk($sformatf("t3_ch1_p%0d", k), near1(d, 32'h8000_01F4), 32'h8000_01F4);
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (i != 1) begin
        rd(0, 32'(i * 4), d); chk($sformatf("t3_ch%0d_idle", i), d, 32'd0);
      end
    end

    // 4: idle timeout, then recovery on the next falling edge
    wait_cyc(25010);
    rd(0, 32'h04, d); chk("t4_ch1_to", d, 32'd0);
    rd(0, 32'h18, d); chk("t4_stat_to", d, 32'd0);
    pa[1] = 1'b1; wait_cyc(300);
    pa[1] = 1'b0; wait_cyc(6);
    rd(0, 32'h04, d); chk("t4_ch1_rearm", near1(d, 32'h8000_012C), 32'h8000_012C);
    rd(0, 32'h24, d); chk("alias_ch1", near1(d, 32'h8000_012C), 32'h8000_012C);

    // 5: 10 MHz instance, two overlapping channels
    pb[0] = 1'b1; pb[5] = 1'b1; wait_cyc(10000);
    pb[5] = 1'b0; wait_cyc(10000);
    pb[0] = 1'b0; wait_cyc(30);
    rd(1, 32'h18, d); chk("t5_stat", d, 32'h0000_2121);
    rd(1, 32'h00, d); chk("t5_ch0", near1(d, 32'h8000_07D0), 32'h8000_07D0);
    rd(1, 32'h14, d); chk("t5_ch5", near1(d, 32'h8000_03E8), 32'h8000_03E8);
    rd(1, 32'h04, d); chk("t5_ch1", d, 32'd0);

    // 6: write ignored; held strobe acks on alternate cycles
    @(negedge clk);
    bus_a.wb_adr_i = 32'h08; bus_a.wb_dat_i = 32'hFFEE_DDCC; bus_a.wb_we_i = 1'b1;
    bus_a.wb_cyc_i = 1'b1;   bus_a.wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_ack%0d", i), {31'd0, bus_a.wb_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus_a.wb_cyc_i = 1'b0; bus_a.wb_stb_i = 1'b0; bus_a.wb_we_i = 1'b0;
    wait_cyc(2);
    rd(0, 32'h08, d); chk("t6_ch2", d, 32'd0);

    chk("err_rty", {31'd0, err_seen}, 32'd0);

    // Reset in the middle of an ack clears it at once
    @(negedge clk);
    bus_a.wb_adr_i = 32'h04; bus_a.wb_cyc_i = 1'b1; bus_a.wb_stb_i = 1'b1;
    @(negedge clk);
    chk("mid_ack_pre", {31'd0, bus_a.wb_ack_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ack_rst", {31'd0, bus_a.wb_ack_o}, 32'd0);
    chk("mid_dat_rst", bus_a.wb_dat_o, 32'd0);
    bus_a.wb_cyc_i = 1'b0; bus_a.wb_stb_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
